// File: rtl/seq_mult_32_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encodings and sizing constants.
package seq_mult_32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/seq_mult_32_step.sv
// One shift-add iteration: conditional add of the multiplicand into the upper half
// with the carry kept, then a logical right shift of the whole accumulator.
module seq_mult_32_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] upper;

    always_comb begin
        upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            upper = upper + {1'b0, mcand};
        end
    end

    assign acc_next = {upper, acc[WIDTH-1:1]};

endmodule

// File: rtl/seq_mult_32.sv
// Multi-cycle signed/unsigned multiplier with START/BUSY/DONE handshake;
// one partial-product step per clock, product published on HI/LO only when complete.
module seq_mult_32
    import seq_mult_32_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    state_t             state, next_state;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    logic [CW-1:0]      count;
    logic               load, step, last;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_in;

    // Operand magnitudes; the most negative value maps onto itself, which is correct unsigned.
    assign mag_a  = (SIGNED && A[WIDTH-1]) ? neg_w(A) : A;
    assign mag_b  = (SIGNED && B[WIDTH-1]) ? neg_w(B) : B;
    assign neg_in = SIGNED ? (A[WIDTH-1] ^ B[WIDTH-1]) : 1'b0;

    seq_mult_32_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    next_state = ST_DONE;
                    last       = 1'b1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_DONE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            count <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            if (load) begin
                acc   <= {{WIDTH{1'b0}}, mag_b};
                mcand <= mag_a;
                neg   <= neg_in;
                count <= '0;
            end else if (step) begin
                acc   <= acc_next;
                count <= count + CW'(1);
            end
            // HI/LO change only on the final step so intermediate sums never leak out.
            if (last) begin
                {HI, LO} <= neg ? neg_2w(acc_next) : acc_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_32.sv
// Randomized self-checking bench: a signed and an unsigned instance run in lockstep
// and are compared against plain 64-bit arithmetic products.
module tb_seq_mult_32;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [31:0] A, B;
    logic        busy_s, done_s, busy_u, done_u;
    logic [31:0] hi_s, lo_s, hi_u, lo_u;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] prev_s, prev_u;

    seq_mult_32 #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .CLK(CLK), .RESET(RESET), .START(START), .A(A), .B(B),
        .BUSY(busy_s), .DONE(done_s), .HI(hi_s), .LO(lo_s)
    );

    seq_mult_32 #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .CLK(CLK), .RESET(RESET), .START(START), .A(A), .B(B),
        .BUSY(busy_u), .DONE(done_u), .HI(hi_u), .LO(lo_u)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint      sa, sb;
        logic [63:0] ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [63:0] exp_s, exp_u;
        int          busy_cnt;
        bit          bad;
        exp_s = model(a, b, 1'b1);
        exp_u = model(a, b, 1'b0);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        busy_cnt = 0;
        bad = 1'b0;
        while ((busy_s || busy_u) && busy_cnt < 200) begin
            busy_cnt++;
            if (busy_s !== busy_u || done_s || done_u ||
                {hi_s, lo_s} !== prev_s || {hi_u, lo_u} !== prev_u) bad = 1'b1;
            if (disturb && busy_cnt == 5) begin
                START = 1'b1;
                A = $urandom;
                B = $urandom;
            end else if (disturb && busy_cnt == 6) begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
        end
        check("busy_len", 64'(busy_cnt), 64'd32);
        check("done_s", {63'd0, done_s}, 64'd1);
        check("done_u", {63'd0, done_u}, 64'd1);
        check("prod_s", {hi_s, lo_s}, exp_s);
        check("prod_u", {hi_u, lo_u}, exp_u);
        check("hold_run", {63'd0, bad}, 64'd0);
        if (disturb) START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("done_pulse", {60'd0, done_s, done_u, busy_s, busy_u}, 64'd0);
        check("keep_s", {hi_s, lo_s}, exp_s);
        prev_s = exp_s;
        prev_u = exp_u;
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        A = '0;
        B = '0;
        prev_s = '0;
        prev_u = '0;
        #12;
        check("rst_ctrl", {60'd0, busy_s, done_s, busy_u, done_u}, 64'd0);
        check("rst_prod_s", {hi_s, lo_s}, 64'd0);
        check("rst_prod_u", {hi_u, lo_u}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;

        run_mult(32'd3, 32'd4, 1'b0);
        check("tp_3x4", {hi_s, lo_s}, 64'h0000_0000_0000_000C);
        run_mult(32'hFFFF_FFFD, 32'd4, 1'b0);
        check("tp_m3x4", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFF4);
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("tp_m1xm1", {hi_s, lo_s}, 64'd1);
        run_mult(32'h8000_0000, 32'h8000_0000, 1'b0);
        check("tp_min_s", {hi_s, lo_s}, 64'h4000_0000_0000_0000);
        check("tp_min_u", {hi_u, lo_u}, 64'h4000_0000_0000_0000);
        run_mult(32'hFFFF_FFFF, 32'd2, 1'b0);
        check("tp_u_ffx2", {hi_u, lo_u}, 64'h0000_0001_FFFF_FFFE);
        run_mult(32'd0, 32'h8000_0001, 1'b0);
        run_mult(32'hFFFF_FFF0, 32'd0, 1'b0);
        run_mult(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_mult($urandom, $urandom, (i % 4) == 0);
        end

        // Asynchronous reset mid-operation, then a fresh multiply.
        A = 32'h7FFF_0001;
        B = 32'hF00D_0003;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        check("mid_rst_ctrl", {60'd0, busy_s, done_s, busy_u, done_u}, 64'd0);
        check("mid_rst_s", {hi_s, lo_s}, 64'd0);
        check("mid_rst_u", {hi_u, lo_u}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        prev_s = '0;
        prev_u = '0;
        @(posedge CLK); #1;
        run_mult(32'd7, 32'd6, 1'b0);
        check("after_rst_42", {hi_s, lo_s}, 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
